wq_fetch: RTL and testbench
===========================

Name: wq_fetch

Overview:
- Read-side initiator for the weight memories (Wq/Wk/Wv style: single port, `write_en` low = read, registered 1-cycle read data).
- On a start pulse it issues `len` consecutive word reads beginning at `base_addr`. It absorbs the memory's read latency in a small FIFO and presents the words as a valid/ready stream to the PE-array weight loader.
- It sits between one weight mem instance and the matmul datapath, and drives the mem's `write_en` and `addr` while it owns the port.

Parameters:
- WIDTH, 64, memory/stream word width in bits.
- LEN_W, 16, width of the `len` input.
- FIFO_DEPTH, 4, read-data buffer depth; power of 2, minimum 2.
- ROW_WORDS, 16, words per 128-byte weight row; used only by the optional feature.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  32  first word address; captured on an accepted start.
- len  in  LEN_W  number of words to fetch; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- mem_write_en  out  1  tied to 0 (this block only reads).
- mem_addr  out  32  read address to the memory.
- mem_rdata  in  WIDTH  memory `data_out`, valid the cycle after a read is issued.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream ready.
- m_data  out  WIDTH  stream word.
- m_last  out  1  marks the final word of a fetch.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE. Outputs reset to busy=0, done=0, m_valid=0, m_last=0, m_data=0, mem_addr=0, mem_write_en=0. The issue counter, the pending flag and the FIFO are cleared.
- Reset mid-fetch: any in-flight read is discarded and no further words are emitted.
- FSM states:
  - IDLE: on start & len!=0, go to FETCH. On start & len==0, go to DONE.
  - FETCH: issue reads; when the `len`-th read issues, go to DRAIN.
  - DRAIN: wait for the FIFO to empty and no read pending; on the last handshake go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Issue rule: in FETCH a read is issued in a cycle when (fifo_count + pending − pop) < FIFO_DEPTH, where pop = m_valid & m_ready.
  - mem_addr = base + issued_count (combinational from registers, 32-bit wrap).
  - `pending` is set for the next cycle.
  - When no read issues, mem_addr holds its last value.
- Capture: the cycle after an issue (`pending`=1), mem_rdata is written into the FIFO. The FIFO can never overflow by construction.
- Stream:
  - m_valid = FIFO not empty; m_data = FIFO head.
  - A word is consumed only on m_valid & m_ready.
  - m_data, m_last and m_valid hold stable while m_valid & !m_ready.
  - m_last = 1 on the head word whose emit index == len−1.
- Latency: start sampled at edge E0 → first mem_addr driven in cycle E0+1 → first m_valid in cycle E0+3.
- Throughput: with m_ready held high, one word per cycle sustained.
- start while busy: ignored. base_addr/len changes after capture: ignored.
- done pulses the cycle after the final handshake. busy deasserts together with the end of the DONE cycle.

Optional Feature:
- Macro WQ_FETCH_ROW_LAST_EN.
- Defined: adds output port m_row_last (1 bit), asserted with the head word whenever (emit index mod ROW_WORDS) == ROW_WORDS−1. It follows the same hold rules as m_last and resets to 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package mhsa_mem_pkg:
  - fetch_state_e enum (IDLE, FETCH, DRAIN, DONE).
  - Constants WEIGHT_WORD_W=64, WEIGHT_SIZE=2048, ROW_WORDS=16.
- Sub-module wq_fetch_fifo: synchronous FIFO (WIDTH+1 bits carrying data and last, FIFO_DEPTH entries). Same-cycle push and pop are allowed; it exposes its count for the issue rule.

Test Plan:
- mem[i]=0x100+i; start with base=0, len=4, m_ready=1 → mem_addr 0,1,2,3 in consecutive cycles; m_data 0x100..0x103 beginning 3 cycles after start; m_last only on 0x103; done pulse the following cycle.
- base=0x40, len=8, m_ready high one cycle in three → exactly 0x140..0x147 in order with no duplicates; stable m_data while stalled; mem_addr never outside 0x40..0x47; outstanding never exceeds 4.
- len=0 start → done=1 one cycle after start; m_valid never asserts; mem_addr unchanged.
- start pulsed again and base_addr changed mid-fetch → ignored; the original stream completes unaltered with a single done.
- rst_n=0 for 1 cycle after the 3rd word → next cycle m_valid=0, busy=0; a new start (base=0, len=2) then yields 0x100, 0x101 correctly.
- With WQ_FETCH_ROW_LAST_EN: base=0, len=2048, m_ready=1 → 2048 words, m_row_last at indices 15, 31, …, 2047 (128 pulses), m_last only at 2047.

Source files
------------

// File: rtl/mhsa_mem_pkg.sv
// ---- mhsa_mem_pkg : shared types/constants for weight-memory access ---- rev 1.0
`default_nettype none

package mhsa_mem_pkg;

  localparam int WEIGHT_WORD_W = 64;
  localparam int WEIGHT_SIZE   = 2048;
  localparam int ROW_WORDS     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/wq_fetch_fifo.sv
// ---- wq_fetch_fifo : read-data buffer, same-cycle push/pop, exposes count ---- rev 1.0
`default_nettype none

module wq_fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is cleared too so the head reads as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else begin
      if (push) begin
        storage[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = storage[rd_ptr];
  assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/wq_fetch.sv
// ---- wq_fetch : weight-memory read initiator -> valid/ready word stream ---- rev 1.0
// Optional m_row_last output enabled by macro WQ_FETCH_ROW_LAST_EN.
`default_nettype none

module wq_fetch #(
  parameter int WIDTH      = mhsa_mem_pkg::WEIGHT_WORD_W,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_WORDS  = mhsa_mem_pkg::ROW_WORDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             mem_write_en,
  output logic [31:0]      mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
`ifdef WQ_FETCH_ROW_LAST_EN
  output logic             m_row_last,
`endif
  output logic             m_last
);

  import mhsa_mem_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("wq_fetch: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (ROW_WORDS < 1) begin : g_row_check
    $error("wq_fetch: ROW_WORDS must be at least 1");
  end

  fetch_state_e     state;
  logic [31:0]      base_r;
  logic [31:0]      last_addr;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] issued;
  logic             pending;
  logic             pending_last;

  logic             pop;
  logic             fifo_empty;
  logic             head_last;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             issue;
  logic             issue_last;

  // Words already buffered plus the one in flight, minus the one leaving now.
  assign pop        = !fifo_empty && m_ready;
  assign occupancy  = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(pending) - (CNT_W+1)'(pop);
  assign issue      = (state == FETCH) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign issue_last = (issued == len_r - LEN_W'(1));

  assign mem_write_en = 1'b0;
  assign mem_addr     = issue ? (base_r + 32'(issued)) : last_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      base_r       <= '0;
      len_r        <= '0;
      issued       <= '0;
      last_addr    <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      done         <= 1'b0;
      pending      <= issue;
      pending_last <= issue && issue_last;
      if (issue) begin
        last_addr <= mem_addr;
        issued    <= issued + LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            base_r <= base_addr;
            len_r  <= len;
            issued <= '0;
            busy   <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (issue && issue_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The tagged word can only reach the head after the last issue.
          if (pop && head_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  wq_fetch_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pending),
    .push_data ({pending_last, mem_rdata}),
    .pop       (pop),
    .head      ({head_last, m_data}),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign m_last  = m_valid && head_last;

`ifdef WQ_FETCH_ROW_LAST_EN
  localparam int ROW_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;

  logic [ROW_W-1:0] row_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_idx <= '0;
    end else if (state == IDLE && start) begin
      row_idx <= '0;
    end else if (pop) begin
      row_idx <= (row_idx == ROW_W'(ROW_WORDS - 1)) ? '0 : row_idx + ROW_W'(1);
    end
  end

  assign m_row_last = m_valid && (row_idx == ROW_W'(ROW_WORDS - 1));
`endif

endmodule

`default_nettype wire

// File: tb/tb_wq_fetch.sv
// ---- tb_wq_fetch : directed self-checking bench for wq_fetch ---- rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_wq_fetch;

  localparam int WIDTH = 64;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             done;
  logic             mem_write_en;
  logic [31:0]      mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
`ifdef WQ_FETCH_ROW_LAST_EN
  logic             m_row_last;
`endif

  int checks = 0;
  int passes = 0;

  logic [WIDTH-1:0] wmem [2048];

  always #5 clk = ~clk;

  // Weight memory: registered read, one cycle latency.
  always @(posedge clk) mem_rdata <= wmem[mem_addr[10:0]];

  wq_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
`ifdef WQ_FETCH_ROW_LAST_EN
    .m_row_last   (m_row_last),
`endif
    .m_last       (m_last)
  );

  // Pulse start for one edge; returns 1ns into the first cycle after it.
  task automatic kick(input logic [31:0] b, input logic [LEN_W-1:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 32'hDEAD_0000; len = 16'd7;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    checks++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_valid); else passes++;
    checks++; if (m_last !== 1'b0) $display("FAIL reset_last: got %b want 0", m_last); else passes++;
    checks++; if (m_data !== 64'h0) $display("FAIL reset_data: got %h want 0", m_data); else passes++;
    checks++; if (mem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", mem_addr); else passes++;
    checks++; if (mem_write_en !== 1'b0) $display("FAIL reset_wen: got %b want 0", mem_write_en); else passes++;
`ifdef WQ_FETCH_ROW_LAST_EN
    checks++; if (m_row_last !== 1'b0) $display("FAIL reset_row_last: got %b want 0", m_row_last); else passes++;
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // base=0, len=4, always ready: exact cycle timeline from the start edge.
  task automatic test_basic;
    logic             exp_v;
    logic [31:0]      exp_a;
    m_ready = 1'b1;
    kick(32'h0, 16'd4);
    for (int p = 1; p <= 8; p++) begin
      @(negedge clk);
      exp_v = (p >= 3 && p <= 6);
      exp_a = (p <= 4) ? 32'(p - 1) : 32'h3;
      if (p <= 5) begin
        checks++; if (mem_addr !== exp_a) $display("FAIL basic_addr p%0d: got %h want %h", p, mem_addr, exp_a); else passes++;
      end
      checks++; if (m_valid !== exp_v) $display("FAIL basic_valid p%0d: got %b want %b", p, m_valid, exp_v); else passes++;
      if (exp_v) begin
        checks++; if (m_data !== 64'h100 + 64'(p - 3)) $display("FAIL basic_data p%0d: got %h want %h", p, m_data, 64'h100 + 64'(p - 3)); else passes++;
        checks++; if (m_last !== (p == 6)) $display("FAIL basic_last p%0d: got %b want %b", p, m_last, (p == 6)); else passes++;
      end
      checks++; if (done !== (p == 7)) $display("FAIL basic_done p%0d: got %b want %b", p, done, (p == 7)); else passes++;
      checks++; if (busy !== (p <= 7)) $display("FAIL basic_busy p%0d: got %b want %b", p, busy, (p <= 7)); else passes++;
    end
  endtask

  // len=0: immediate done, no stream, address bus holds its last read (3).
  task automatic test_len0;
    kick(32'h99, 16'd0);
    for (int p = 1; p <= 2; p++) begin
      @(negedge clk);
      checks++; if (done !== (p == 1)) $display("FAIL len0_done p%0d: got %b want %b", p, done, (p == 1)); else passes++;
      checks++; if (busy !== (p == 1)) $display("FAIL len0_busy p%0d: got %b want %b", p, busy, (p == 1)); else passes++;
      checks++; if (m_valid !== 1'b0) $display("FAIL len0_valid p%0d: got %b want 0", p, m_valid); else passes++;
      checks++; if (mem_addr !== 32'h3) $display("FAIL len0_addr p%0d: got %h want 3", p, mem_addr); else passes++;
    end
  endtask

  // base=0x40, len=8, ready one cycle in three.
  task automatic test_stall;
    int               n = 0;
    int               dones = 0;
    logic             prev_stall = 1'b0;
    logic [WIDTH:0]   prev = '0;
    kick(32'h40, 16'd8);
    for (int cyc = 0; cyc < 150; cyc++) begin
      m_ready = (cyc % 3 == 2);
      @(negedge clk);
      if (busy) begin
        checks++; if (mem_addr < 32'h40 || mem_addr > 32'h47) $display("FAIL stall_addr_range: got %h want 40..47", mem_addr); else passes++;
      end
      if (prev_stall) begin
        checks++; if (!m_valid || {m_last, m_data} !== prev) $display("FAIL stall_hold: got v=%b %h want v=1 %h", m_valid, {m_last, m_data}, prev); else passes++;
      end
      if (m_valid && m_ready) begin
        checks++; if (m_data !== 64'h140 + 64'(n)) $display("FAIL stall_data #%0d: got %h want %h", n, m_data, 64'h140 + 64'(n)); else passes++;
        checks++; if (m_last !== (n == 7)) $display("FAIL stall_last #%0d: got %b want %b", n, m_last, (n == 7)); else passes++;
        n++;
      end
      if (done) dones++;
      prev_stall = m_valid && !m_ready;
      prev = {m_last, m_data};
      if (n >= 8 && dones >= 1 && !busy) break;
      @(posedge clk); #1;
    end
    checks++; if (n !== 8) $display("FAIL stall_count: got %0d want 8", n); else passes++;
    checks++; if (dones !== 1) $display("FAIL stall_done_count: got %0d want 1", dones); else passes++;
    m_ready = 1'b1;
  endtask

  // Second start and base change mid-fetch must not disturb the stream.
  task automatic test_restart;
    int n = 0;
    int dones = 0;
    m_ready = 1'b1;
    kick(32'h0, 16'd4);
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc == 1 || cyc == 3) begin
        start = 1'b1; base_addr = 32'h40; len = 16'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++; if (m_data !== 64'h100 + 64'(n)) $display("FAIL restart_data #%0d: got %h want %h", n, m_data, 64'h100 + 64'(n)); else passes++;
        checks++; if (m_last !== (n == 3)) $display("FAIL restart_last #%0d: got %b want %b", n, m_last, (n == 3)); else passes++;
        n++;
      end
      if (done) dones++;
      @(posedge clk); #1;
    end
    checks++; if (n !== 4) $display("FAIL restart_count: got %0d want 4", n); else passes++;
    checks++; if (dones !== 1) $display("FAIL restart_done_count: got %0d want 1", dones); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL restart_busy_end: got %b want 0", busy); else passes++;
  endtask

  // Reset right after the third word, then a clean base=0 len=2 fetch.
  task automatic test_reset_mid;
    int n = 0;
    int dones = 0;
    m_ready = 1'b1;
    kick(32'h0, 16'd8);
    for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
      @(negedge clk);
      if (m_valid && m_ready) n++;
    end
    checks++; if (n !== 3) $display("FAIL rmid_pre_words: got %0d want 3", n); else passes++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      checks++; if (m_valid !== 1'b0) $display("FAIL rmid_valid p%0d: got %b want 0", p, m_valid); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL rmid_busy p%0d: got %b want 0", p, busy); else passes++;
    end
    n = 0;
    kick(32'h0, 16'd2);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++; if (m_data !== 64'h100 + 64'(n)) $display("FAIL rmid_data #%0d: got %h want %h", n, m_data, 64'h100 + 64'(n)); else passes++;
        checks++; if (m_last !== (n == 1)) $display("FAIL rmid_last #%0d: got %b want %b", n, m_last, (n == 1)); else passes++;
        n++;
      end
      if (done) dones++;
    end
    checks++; if (n !== 2) $display("FAIL rmid_count: got %0d want 2", n); else passes++;
    checks++; if (dones !== 1) $display("FAIL rmid_done_count: got %0d want 1", dones); else passes++;
  endtask

`ifdef WQ_FETCH_ROW_LAST_EN
  task automatic test_row_last;
    int n = 0;
    int rows = 0;
    int dones = 0;
    m_ready = 1'b1;
    kick(32'h0, 16'd2048);
    for (int cyc = 0; cyc < 2200; cyc++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++; if (m_data !== 64'h100 + 64'(n)) $display("FAIL row_data #%0d: got %h want %h", n, m_data, 64'h100 + 64'(n)); else passes++;
        checks++; if (m_row_last !== (n % 16 == 15)) $display("FAIL row_flag #%0d: got %b want %b", n, m_row_last, (n % 16 == 15)); else passes++;
        checks++; if (m_last !== (n == 2047)) $display("FAIL row_last_flag #%0d: got %b want %b", n, m_last, (n == 2047)); else passes++;
        if (m_row_last) rows++;
        n++;
      end
      if (done) dones++;
      if (dones >= 1 && !busy) break;
    end
    checks++; if (n !== 2048) $display("FAIL row_count: got %0d want 2048", n); else passes++;
    checks++; if (rows !== 128) $display("FAIL row_pulses: got %0d want 128", rows); else passes++;
    checks++; if (dones !== 1) $display("FAIL row_done_count: got %0d want 1", dones); else passes++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) wmem[i] = 64'h100 + 64'(i);
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_restart();
    test_reset_mid();
`ifdef WQ_FETCH_ROW_LAST_EN
    test_row_last();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
